// File: rtl/rr_pkg.sv
// Shared rename-stage definitions: default sizing constants and the
// physical-tag / free-list-pointer types.
package rr_pkg;

    localparam int P_ADDR_WIDTH = 7;
    localparam int L_ADDR_WIDTH = 5;
    localparam int C_NUM        = 4;
    localparam int INSTR_COUNT  = 2;

    typedef logic [P_ADDR_WIDTH-1:0] preg_t;
    typedef logic [P_ADDR_WIDTH:0]   ptr_t;

endpackage

// File: rtl/free_list_if.sv
// Rename/commit side of the free list: allocation request and tags,
// release lanes from commit, checkpoint take/restore controls.
//   master : rename/commit logic (drives requests, releases, checkpoints)
//   slave  : free_list (drives alloc_ready, alloc_data)
interface free_list_if #(
    parameter int P_ADDR_WIDTH = rr_pkg::P_ADDR_WIDTH,
    parameter int INSTR_COUNT  = rr_pkg::INSTR_COUNT,
    parameter int C_NUM        = rr_pkg::C_NUM
);
    logic [INSTR_COUNT-1:0]                   alloc_req;
    logic                                     alloc_ready;
    logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] alloc_data;
    logic [INSTR_COUNT-1:0]                   release_en;
    logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] release_data;
    logic                                     take_checkpoint;
    logic                                     restore_checkpoint;
    logic [$clog2(C_NUM)-1:0]                 new_checkpoint;

    modport master (
        output alloc_req,
        input  alloc_ready,
        input  alloc_data,
        output release_en,
        output release_data,
        output take_checkpoint,
        output restore_checkpoint,
        output new_checkpoint
    );

    modport slave (
        input  alloc_req,
        output alloc_ready,
        output alloc_data,
        input  release_en,
        input  release_data,
        input  take_checkpoint,
        input  restore_checkpoint,
        input  new_checkpoint
    );
endinterface

// File: rtl/free_list_lane_prefix_count.sv
// lane_prefix_count: exclusive prefix popcount of a lane vector.
//   vec    : per-lane valid bits
//   prefix : prefix[i] = popcount(vec[i-1:0])
//   total  : popcount(vec)
module lane_prefix_count #(
    parameter int N = 2,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0]        vec,
    output logic [N-1:0][W-1:0] prefix,
    output logic [W-1:0]        total
);
    always_comb begin
        logic [W-1:0] acc;
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = acc;
            acc       = acc + W'(vec[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/free_list.sv
// free_list: circular queue of free physical register tags for rename.
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : alloc_req/alloc_ready/alloc_data, release_en/release_data,
//                   take_checkpoint, restore_checkpoint, new_checkpoint
//   free_count    : registered number of free entries (wr_ptr - rd_ptr)
// Optional macro FREE_LIST_WATERMARK_EN adds wm_clr (in) and min_free (out),
// a low-water mark of free_count.
module free_list
    import rr_pkg::*;
#(
    parameter int P_ADDR_WIDTH = rr_pkg::P_ADDR_WIDTH,
    parameter int L_ADDR_WIDTH = rr_pkg::L_ADDR_WIDTH,
    parameter int C_NUM        = rr_pkg::C_NUM,
    parameter int INSTR_COUNT  = rr_pkg::INSTR_COUNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    free_list_if.slave            bus,
    output logic [P_ADDR_WIDTH:0] free_count
`ifdef FREE_LIST_WATERMARK_EN
    ,
    input  logic                  wm_clr,
    output logic [P_ADDR_WIDTH:0] min_free
`endif
);
    localparam int P_REGS = 2 ** P_ADDR_WIDTH;
    localparam int L_REGS = 2 ** L_ADDR_WIDTH;
    localparam int PTR_W  = P_ADDR_WIDTH + 1;
    localparam int CW     = $clog2(INSTR_COUNT + 1);
    localparam int CIW    = $clog2(C_NUM);

    logic [P_ADDR_WIDTH-1:0] mem [P_REGS];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [PTR_W-1:0]        rd_nxt, wr_nxt, fc_nxt;
    logic [PTR_W-1:0]        ckpt [C_NUM];
    logic [CIW-1:0]          ckpt_head;

    logic [INSTR_COUNT-1:0][CW-1:0]           a_prefix, r_prefix;
    logic [CW-1:0]                            a_total, r_total;
    logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0] rd_idx, wr_idx;

    lane_prefix_count #(.N(INSTR_COUNT), .W(CW)) u_alloc_cnt (
        .vec    (bus.alloc_req),
        .prefix (a_prefix),
        .total  (a_total)
    );

    lane_prefix_count #(.N(INSTR_COUNT), .W(CW)) u_release_cnt (
        .vec    (bus.release_en),
        .prefix (r_prefix),
        .total  (r_total)
    );

    // Requesting lanes take consecutive entries starting at rd_ptr; releasing
    // lanes fill consecutive entries starting at wr_ptr.
    always_comb begin
        rd_idx         = '0;
        wr_idx         = '0;
        bus.alloc_data = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            rd_idx[i]         = rd_ptr[P_ADDR_WIDTH-1:0] + P_ADDR_WIDTH'(a_prefix[i]);
            wr_idx[i]         = wr_ptr[P_ADDR_WIDTH-1:0] + P_ADDR_WIDTH'(r_prefix[i]);
            bus.alloc_data[i] = mem[rd_idx[i]];
        end
    end

    // All-or-nothing: a partial grant would split one rename group.
    always_comb begin
        bus.alloc_ready = (free_count >= PTR_W'(a_total)) && !bus.restore_checkpoint;
        rd_nxt = rd_ptr;
        if (bus.restore_checkpoint)
            rd_nxt = ckpt[bus.new_checkpoint];
        else if (bus.alloc_ready)
            rd_nxt = rd_ptr + PTR_W'(a_total);
        wr_nxt = wr_ptr + PTR_W'(r_total);
        fc_nxt = wr_nxt - rd_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= PTR_W'(P_REGS - L_REGS);
            free_count <= PTR_W'(P_REGS - L_REGS);
            ckpt_head  <= '0;
            for (int k = 0; k < C_NUM; k++)
                ckpt[k] <= '0;
            // Tags 0..L_REGS-1 are the architectural mappings at reset; the
            // upper entries are don't-care and simply get a wrapped value.
            for (int k = 0; k < P_REGS; k++)
                mem[k] <= P_ADDR_WIDTH'(L_REGS + k);
        end else begin
            rd_ptr     <= rd_nxt;
            wr_ptr     <= wr_nxt;
            free_count <= fc_nxt;
            for (int i = 0; i < INSTR_COUNT; i++)
                if (bus.release_en[i])
                    mem[wr_idx[i]] <= bus.release_data[i];
            // Snapshot holds the pre-edge rd_ptr so it matches the rename
            // table's pre-write checkpoint. Restore overrides any take.
            if (bus.restore_checkpoint) begin
                ckpt_head <= bus.new_checkpoint + CIW'(1);
            end else if (bus.take_checkpoint) begin
                ckpt[ckpt_head] <= rd_ptr;
                ckpt_head       <= ckpt_head + CIW'(1);
            end
        end
    end

`ifdef FREE_LIST_WATERMARK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            min_free <= PTR_W'(P_REGS - L_REGS);
        else if (wm_clr)
            min_free <= free_count;
        else if (fc_nxt < min_free)
            min_free <= fc_nxt;
    end
`endif

    // Releasing more tags than were ever allocated overfills the queue.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        fc_nxt <= PTR_W'(P_REGS));

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
    import rr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [P_ADDR_WIDTH:0] free_count;
`ifdef FREE_LIST_WATERMARK_EN
    logic                  wm_clr;
    logic [P_ADDR_WIDTH:0] min_free;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    free_list_if #(.P_ADDR_WIDTH(P_ADDR_WIDTH), .INSTR_COUNT(INSTR_COUNT), .C_NUM(C_NUM)) bus ();

    free_list #(
        .P_ADDR_WIDTH (P_ADDR_WIDTH),
        .L_ADDR_WIDTH (L_ADDR_WIDTH),
        .C_NUM        (C_NUM),
        .INSTR_COUNT  (INSTR_COUNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .free_count (free_count)
`ifdef FREE_LIST_WATERMARK_EN
        ,
        .wm_clr     (wm_clr),
        .min_free   (min_free)
`endif
    );

    task automatic idle_inputs();
        bus.alloc_req          = '0;
        bus.release_en         = '0;
        bus.release_data       = '0;
        bus.take_checkpoint    = 1'b0;
        bus.restore_checkpoint = 1'b0;
        bus.new_checkpoint     = '0;
`ifdef FREE_LIST_WATERMARK_EN
        wm_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        total++; if (free_count !== 8'd96) begin bad++; $display("FAIL reset_free_count got=%0d want=96", free_count); end
        total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.alloc_ready); end
`ifdef FREE_LIST_WATERMARK_EN
        total++; if (min_free !== 8'd96) begin bad++; $display("FAIL reset_min_free got=%0d want=96", min_free); end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alloc_both();
        bus.alloc_req = 2'b11;
        #1;
        total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL both_ready got=%0b want=1", bus.alloc_ready); end
        total++; if (bus.alloc_data[0] !== 7'd32) begin bad++; $display("FAIL both_lane0 got=%0d want=32", bus.alloc_data[0]); end
        total++; if (bus.alloc_data[1] !== 7'd33) begin bad++; $display("FAIL both_lane1 got=%0d want=33", bus.alloc_data[1]); end
        @(negedge clk);
        bus.alloc_req = 2'b00;
        #1;
        total++; if (free_count !== 8'd94) begin bad++; $display("FAIL both_free_count got=%0d want=94", free_count); end
    endtask

    task automatic test_lane_order();
        do_reset();
        bus.alloc_req = 2'b10;
        #1;
        total++; if (bus.alloc_data[1] !== 7'd32) begin bad++; $display("FAIL order_lane1 got=%0d want=32", bus.alloc_data[1]); end
        @(negedge clk);
        bus.alloc_req = 2'b01;
        #1;
        total++; if (bus.alloc_data[0] !== 7'd33) begin bad++; $display("FAIL order_lane0 got=%0d want=33", bus.alloc_data[0]); end
        @(negedge clk);
        bus.alloc_req = 2'b00;
        #1;
        total++; if (free_count !== 8'd94) begin bad++; $display("FAIL order_free_count got=%0d want=94", free_count); end
    endtask

    task automatic test_checkpoint();
        do_reset();
        bus.take_checkpoint = 1'b1;           // slot 0 <- rd_ptr 0
        @(negedge clk);
        bus.take_checkpoint = 1'b0;
        bus.alloc_req = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        total++; if (free_count !== 8'd90) begin bad++; $display("FAIL ckpt_pre_restore got=%0d want=90", free_count); end
        bus.restore_checkpoint = 1'b1;
        bus.new_checkpoint     = 2'd0;
        #1;
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL ckpt_restore_ready got=%0b want=0", bus.alloc_ready); end
        @(negedge clk);
        bus.restore_checkpoint = 1'b0;
        #1;
        total++; if (free_count !== 8'd96) begin bad++; $display("FAIL ckpt_restored_count got=%0d want=96", free_count); end
        total++; if (bus.alloc_data[0] !== 7'd32 || bus.alloc_data[1] !== 7'd33)
            begin bad++; $display("FAIL ckpt_realloc got=%0d,%0d want=32,33", bus.alloc_data[0], bus.alloc_data[1]); end
        @(negedge clk);
        bus.take_checkpoint = 1'b1;           // head is 1: slot 1 <- rd_ptr 2
        #1;
        total++; if (bus.alloc_data[0] !== 7'd34) begin bad++; $display("FAIL ckpt_take_lane0 got=%0d want=34", bus.alloc_data[0]); end
        @(negedge clk);
        bus.take_checkpoint = 1'b0;
        @(negedge clk);
        bus.restore_checkpoint = 1'b1;
        bus.new_checkpoint     = 2'd1;
        @(negedge clk);
        bus.restore_checkpoint = 1'b0;
        bus.alloc_req = 2'b11;
        #1;
        total++; if (free_count !== 8'd94) begin bad++; $display("FAIL ckpt_head_slot1_count got=%0d want=94", free_count); end
        total++; if (bus.alloc_data[0] !== 7'd34 || bus.alloc_data[1] !== 7'd35)
            begin bad++; $display("FAIL ckpt_head_slot1_data got=%0d,%0d want=34,35", bus.alloc_data[0], bus.alloc_data[1]); end
        @(negedge clk);
        bus.alloc_req = 2'b00;
    endtask

    task automatic test_partial();
        do_reset();
        bus.alloc_req = 2'b11;
        repeat (47) @(negedge clk);
        bus.alloc_req = 2'b01;
        @(negedge clk);
        bus.alloc_req = 2'b11;
        #1;
        total++; if (free_count !== 8'd1) begin bad++; $display("FAIL partial_count got=%0d want=1", free_count); end
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL partial_ready got=%0b want=0", bus.alloc_ready); end
        @(negedge clk);
        #1;
        total++; if (free_count !== 8'd1) begin bad++; $display("FAIL partial_stall_count got=%0d want=1", free_count); end
        bus.release_en      = 2'b01;
        bus.release_data[0] = 7'd5;
        @(negedge clk);
        bus.release_en = 2'b00;
        #1;
        total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL partial_after_rel_ready got=%0b want=1", bus.alloc_ready); end
        total++; if (bus.alloc_data[0] !== 7'd127 || bus.alloc_data[1] !== 7'd5)
            begin bad++; $display("FAIL partial_after_rel_data got=%0d,%0d want=127,5", bus.alloc_data[0], bus.alloc_data[1]); end
        @(negedge clk);
        bus.alloc_req = 2'b01;
        #1;
        total++; if (free_count !== 8'd0) begin bad++; $display("FAIL empty_count got=%0d want=0", free_count); end
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL empty_ready got=%0b want=0", bus.alloc_ready); end
        bus.alloc_req = 2'b00;
        #1;
        total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL empty_noreq_ready got=%0b want=1", bus.alloc_ready); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.take_checkpoint = 1'b1;           // slot 0 <- 0
        @(negedge clk);
        bus.take_checkpoint = 1'b0;
        bus.alloc_req = 2'b11;
        repeat (2) @(negedge clk);
        bus.restore_checkpoint = 1'b1;
        bus.new_checkpoint     = 2'd0;
        bus.take_checkpoint    = 1'b1;        // must be ignored
        bus.release_en         = 2'b11;
        bus.release_data[0]    = 7'd9;
        bus.release_data[1]    = 7'd7;
        #1;
        total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL same_ready got=%0b want=0", bus.alloc_ready); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (free_count !== 8'd98) begin bad++; $display("FAIL same_count got=%0d want=98", free_count); end
        bus.restore_checkpoint = 1'b1;
        bus.new_checkpoint     = 2'd0;
        @(negedge clk);
        idle_inputs();
        bus.alloc_req = 2'b11;
        #1;
        total++; if (free_count !== 8'd98) begin bad++; $display("FAIL same_take_ignored got=%0d want=98", free_count); end
        total++; if (bus.alloc_data[0] !== 7'd32 || bus.alloc_data[1] !== 7'd33)
            begin bad++; $display("FAIL same_realloc got=%0d,%0d want=32,33", bus.alloc_data[0], bus.alloc_data[1]); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_wrap();
        int q[$];
        int e0, e1;
        do_reset();
        for (int t = 32; t < 128; t++) q.push_back(t);
        for (int c = 0; c < 300; c++) begin
            bus.alloc_req  = 2'b11;
            bus.release_en = 2'b00;
            #1;
            e0 = q.pop_front();
            e1 = q.pop_front();
            total++; if (bus.alloc_ready !== 1'b1 || free_count !== 8'd96)
                begin bad++; $display("FAIL wrap_state c=%0d got ready=%0b count=%0d want ready=1 count=96", c, bus.alloc_ready, free_count); end
            total++; if (bus.alloc_data[0] !== 7'(e0) || bus.alloc_data[1] !== 7'(e1))
                begin bad++; $display("FAIL wrap_data c=%0d got=%0d,%0d want=%0d,%0d", c, bus.alloc_data[0], bus.alloc_data[1], e0, e1); end
            bus.release_en      = 2'b11;
            bus.release_data[0] = 7'(e1);
            bus.release_data[1] = 7'(e0);
            q.push_back(e1);
            q.push_back(e0);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        total++; if (free_count !== 8'd96) begin bad++; $display("FAIL wrap_final_count got=%0d want=96", free_count); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_alloc_both();
        test_lane_order();
        test_checkpoint();
        test_partial();
        test_same_cycle();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
